// File: rtl/img_pkg.sv
// Shared image-pipeline types and defaults: sequencer state encoding, width helper,
// and the frame geometry reused by the median and sobel blocks.
package img_pkg;
  localparam int IMG_DATA_WIDTH = 8;
  localparam int IMG_WIDTH      = 200;
  localparam int IMG_HEIGHT     = 200;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LINE   = 2'd1,
    HBLANK = 2'd2,
    FLUSH  = 2'd3
  } seq_state_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/frame_sequencer.sv
// Raster-order frame reader feeding the median->sobel chain; pix trails rd_en by one cycle, no backpressure.
// FRAME_SEQ_AUTO_RESTART_EN: relaunch the next frame straight out of FLUSH instead of returning to IDLE.
module frame_sequencer
  import img_pkg::*;
#(
  parameter int DATA_WIDTH   = IMG_DATA_WIDTH,
  parameter int WIDTH        = IMG_WIDTH,
  parameter int HEIGHT       = IMG_HEIGHT,
  parameter int H_BLANK      = 0,
  parameter int FLUSH_CYCLES = 4,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pix,
  output logic                  pix_valid,
  output logic                  pix_hsync,
  output logic                  pix_vsync,
  output logic                  busy,
  output logic                  done
);
  localparam int COL_W   = clog2_min1(WIDTH);
  localparam int ROW_W   = clog2_min1(HEIGHT);
  localparam int CNT_MAX = (H_BLANK > FLUSH_CYCLES) ? H_BLANK : FLUSH_CYCLES;
  localparam int CNT_W   = clog2_min1(CNT_MAX + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  seq_state_t            state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_d, done_q;
  logic                  pix_valid_q, pix_vsync_q;
  logic                  abort_act;

  assign abort_act = abort && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LINE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
        end
      end
      LINE: begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          cnt_d = '0;
          if (row_q == ROW_LAST) begin
            // Park the address at 0 so IDLE (or an auto restart) reads from the frame origin.
            state_d = FLUSH;
            row_d   = '0;
            addr_d  = '0;
          end else if (H_BLANK > 0) begin
            state_d = HBLANK;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      HBLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HB_LAST) begin
          state_d = LINE;
          row_d   = row_q + ROW_W'(1);
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == FL_LAST) begin
          done_d = 1'b1;
          cnt_d  = '0;
`ifdef FRAME_SEQ_AUTO_RESTART_EN
          state_d = LINE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_act) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      cnt_d   = '0;
      addr_d  = '0;
      done_d  = 1'b0;
    end
  end

  assign rd_en = (state_q == LINE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_vsync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      pix_valid_q <= rd_en & ~abort_act;
      // vsync spans blanking; it drops when the last pixel has left (first FLUSH cycle without rd_en).
      if (abort_act)
        pix_vsync_q <= 1'b0;
      else if (rd_en)
        pix_vsync_q <= 1'b1;
      else if (state_q == FLUSH)
        pix_vsync_q <= 1'b0;
    end
  end

  assign rd_addr   = addr_q;
  assign pix       = pix_valid_q ? rd_data : '0;
  assign pix_valid = pix_valid_q;
  assign pix_hsync = pix_valid_q;
  assign pix_vsync = pix_vsync_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule
